// File: rtl/ldo_trim_seq.sv
// Purpose: Wishbone-programmable one-hot trim sequencer that soft-starts a bank of LDOs channel by channel.
// Latency: Wishbone ack one cycle after request; each trim step every RAMP_DIV cycles, SETTLE_CYC settle per channel.
// Backpressure: no back-to-back ack; a held request is served once per two cycles, GO outside IDLE is ignored.
module ldo_trim_seq #(
   parameter int NUM_CH     = 3,
   parameter int TRIM_W     = 16,
   parameter int RAMP_DIV   = 256,
   parameter int SETTLE_CYC = 1024,
   parameter logic [NUM_CH*8-1:0] RST_TGT = {8'd10, 8'd8, 8'd6}
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_ni,
   input  logic                     wbs_cyc_i,
   input  logic                     wbs_stb_i,
   input  logic                     wbs_we_i,
   input  logic [3:0]               wbs_sel_i,
   input  logic [31:0]              wbs_adr_i,
   input  logic [31:0]              wbs_dat_i,
   output logic [31:0]              wbs_dat_o,
   output logic                     wbs_ack_o,
   output logic [NUM_CH*TRIM_W-1:0] trim_o,
   output logic                     busy_o,
   output logic                     irq_o
);

   localparam int IDX_W   = $clog2(TRIM_W);
   localparam int ACT_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_MAX = (RAMP_DIV > SETTLE_CYC) ? RAMP_DIV : SETTLE_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RAMP   = 2'd1,
      S_SETTLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_cur [NUM_CH];
   logic [IDX_W-1:0]   r_tgt [NUM_CH];
   logic [IDX_W-1:0]   r_lat [NUM_CH];
   logic [NUM_CH-1:0]  r_ch_en;
   logic [NUM_CH-1:0]  r_done;
   logic [ACT_W-1:0]   r_act;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ack;
   logic [31:0]        r_dat;

   logic               w_req;
   logic               w_wr;
   logic               w_ctrl_wr;
   logic               w_go;
   logic               w_abort;
   logic [NUM_CH-1:0]  w_en_eff;
   logic [IDX_W-1:0]   w_tgt_wval;
   logic [IDX_W-1:0]   w_cur_act;
   logic [IDX_W-1:0]   w_tgt_act;
   logic [IDX_W-1:0]   w_cur_step;
   logic               w_nxt_vld;
   logic [ACT_W-1:0]   w_nxt_ch;
   logic               w_start;
   logic               w_step;
   logic               w_settled;
   logic [31:0]        w_rdata;
   logic               w_unused;

   // A request is taken only while ack is low, which forbids back-to-back acks.
   assign w_req     = wbs_cyc_i & wbs_stb_i & ~r_ack;
   assign w_wr      = w_req & wbs_we_i & wbs_sel_i[0];
   assign w_ctrl_wr = w_wr & (wbs_adr_i[7:0] == 8'h00);
   assign w_go      = w_ctrl_wr & wbs_dat_i[0];
   assign w_abort   = w_ctrl_wr & wbs_dat_i[1];
   // A CTRL write carrying both a new enable mask and GO starts with the new mask.
   assign w_en_eff  = w_ctrl_wr ? wbs_dat_i[8 +: NUM_CH] : r_ch_en;
   assign w_tgt_wval = (wbs_dat_i >= 32'(TRIM_W)) ? IDX_W'(TRIM_W - 1) : wbs_dat_i[IDX_W-1:0];
   assign w_unused  = &{1'b0, wbs_adr_i[31:8], wbs_sel_i[3:1]};

   // Current and latched target of the active channel.
   always_comb begin
      w_cur_act = '0;
      w_tgt_act = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_act == ACT_W'(i)) begin
            w_cur_act = r_cur[i];
            w_tgt_act = r_lat[i];
         end
      end
   end

   assign w_cur_step = (w_tgt_act > w_cur_act) ? w_cur_act + IDX_W'(1) : w_cur_act - IDX_W'(1);

   // Lowest enabled channel: from 0 when starting, above the active one when advancing.
   always_comb begin
      w_nxt_vld = 1'b0;
      w_nxt_ch  = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (w_en_eff[i] && ((r_state == S_IDLE) || (ACT_W'(i) > r_act))) begin
            w_nxt_vld = 1'b1;
            w_nxt_ch  = ACT_W'(i);
         end
      end
   end

   // Sequencer next state and the datapath strobes it issues.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_step      = 1'b0;
      w_settled   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_go && !w_abort) begin
               w_start     = 1'b1;
               w_state_nxt = w_nxt_vld ? S_RAMP : S_DONE;
            end
         end
         S_RAMP: begin
            if (w_abort) begin
               w_state_nxt = S_IDLE;
            end else if (w_cur_act == w_tgt_act) begin
               w_state_nxt = S_SETTLE;
            end else if (r_cnt == CNT_W'(RAMP_DIV - 1)) begin
               w_step = 1'b1;
               if (w_cur_step == w_tgt_act) begin
                  w_state_nxt = S_SETTLE;
               end
            end
         end
         S_SETTLE: begin
            if (w_abort) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
               w_settled   = 1'b1;
               w_state_nxt = w_nxt_vld ? S_RAMP : S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Step/settle counter, channel codes, latched targets, done flags and active channel.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_cnt  <= '0;
         r_done <= '0;
         r_act  <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            r_cur[i] <= '0;
            r_lat[i] <= RST_TGT[i*8 +: IDX_W];
         end
      end else begin
         if ((w_state_nxt != r_state) || w_step) begin
            r_cnt <= '0;
         end else if ((r_state == S_RAMP) || (r_state == S_SETTLE)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_start) begin
            r_done <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
               r_lat[i] <= r_tgt[i];
            end
         end
         if (w_step) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (r_act == ACT_W'(i)) begin
                  r_cur[i] <= w_cur_step;
               end
            end
         end
         if (w_settled) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (r_act == ACT_W'(i)) begin
                  r_done[i] <= 1'b1;
               end
            end
         end
         if ((w_start || w_settled) && w_nxt_vld) begin
            r_act <= w_nxt_ch;
         end
      end
   end

   // Software-visible enable mask and per-channel targets.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_ch_en <= '1;
         for (int i = 0; i < NUM_CH; i++) begin
            r_tgt[i] <= RST_TGT[i*8 +: IDX_W];
         end
      end else begin
         if (w_ctrl_wr) begin
            r_ch_en <= wbs_dat_i[8 +: NUM_CH];
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_wr && (wbs_adr_i[7:0] == 8'(16 + 4*i))) begin
               r_tgt[i] <= w_tgt_wval;
            end
         end
      end
   end

   // Read mux; unmapped addresses read zero.
   always_comb begin
      w_rdata = '0;
      if (wbs_adr_i[7:0] == 8'h00) begin
         w_rdata[8 +: NUM_CH] = r_ch_en;
      end
      if (wbs_adr_i[7:0] == 8'h04) begin
         w_rdata[0]           = busy_o;
         w_rdata[2:1]         = r_state;
         w_rdata[8 +: NUM_CH] = r_done;
         w_rdata[19:16]       = 4'(r_act);
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (wbs_adr_i[7:0] == 8'(16 + 4*i)) begin
            w_rdata = 32'(r_tgt[i]);
         end
         if (wbs_adr_i[7:0] == 8'(64 + 4*i)) begin
            w_rdata = 32'(r_cur[i]);
         end
      end
   end

   // Single-cycle ack with read data held only in the ack cycle.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_ack <= 1'b0;
         r_dat <= '0;
      end else begin
         r_ack <= w_req;
         r_dat <= (w_req && !wbs_we_i) ? w_rdata : '0;
      end
   end

   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_dat;
   assign busy_o    = (r_state == S_RAMP) || (r_state == S_SETTLE);
   assign irq_o     = (r_state == S_DONE);

   // One-hot decode of each channel's current index.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_trim
      assign trim_o[g*TRIM_W +: TRIM_W] = TRIM_W'(1) << r_cur[g];
   end

endmodule

// File: tb/tb_ldo_trim_seq.sv
module tb_ldo_trim_seq;

   localparam int RD = 4;
   localparam int SC = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = '0;
   logic [31:0] dat_w = '0;
   logic [31:0] dat_r;
   logic        ack;
   logic [47:0] trim;
   logic        busy;
   logic        irq;

   ldo_trim_seq #(
      .NUM_CH(3), .TRIM_W(16), .RAMP_DIV(RD), .SETTLE_CYC(SC),
      .RST_TGT({8'd10, 8'd8, 8'd6})
   ) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_dat_o(dat_r), .wbs_ack_o(ack),
      .trim_o(trim), .busy_o(busy), .irq_o(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [47:0] trim;
      int          gap;
   } exp_t;

   exp_t        sb[$];
   int          m_cur[3];
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc_n = 0;
   int          irq_total = 0;
   bit          mon_en = 1'b0;
   logic [47:0] mon_last;
   int          mon_cyc = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [47:0] trim_of();
      logic [15:0] one;
      one = 16'h0001;
      return {one << m_cur[2], one << m_cur[1], one << m_cur[0]};
   endfunction

   task automatic push_ramp(input int ch, input int from, input int to, input int first_gap);
      exp_t e;
      int   v;
      bit   first;
      v = from;
      first = 1'b1;
      while (v != to) begin
         v = (to > from) ? v + 1 : v - 1;
         m_cur[ch] = v;
         e.trim = trim_of();
         e.gap  = first ? first_gap : RD;
         sb.push_back(e);
         first = 1'b0;
      end
   endtask

   always @(posedge clk) cyc_n++;

   // Scoreboard: every trim change pops one expected code and checks step spacing.
   always @(negedge clk) begin
      exp_t e;
      if (irq === 1'b1) irq_total++;
      if (mon_en && (trim !== mon_last)) begin
         if (sb.size() == 0) begin
            check_val("trim_unexpected", trim, mon_last);
         end else begin
            e = sb.pop_front();
            check_val("trim_step", trim, e.trim);
            if (e.gap != 0) check_val("step_gap", cyc_n - mon_cyc, e.gap);
         end
         mon_cyc = cyc_n;
      end
      mon_last = trim;
   end

   task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d, output logic [31:0] q);
      bit got;
      got = 1'b0;
      q = '0;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF; adr = a; dat_w = d;
      for (int k = 0; k < 10 && !got; k++) begin
         @(posedge clk);
         #1;
         if (ack) begin
            got = 1'b1;
            q = dat_r;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
      if (!got) check_val("ack_timeout", ack, 1'b1);
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] q;
      wb_xfer(1'b1, a, d, q);
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] q);
      wb_xfer(1'b0, a, '0, q);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 600 && busy; k++) @(negedge clk);
      repeat (2) @(negedge clk);
      check_val("idle_reached", busy, 1'b0);
   endtask

   task automatic wait_ch0(input logic [15:0] code);
      for (int k = 0; k < 100 && trim[15:0] !== code; k++) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int          irq0;

      // Reset state
      m_cur[0] = 0; m_cur[1] = 0; m_cur[2] = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("rst_trim", trim, 48'h0001_0001_0001);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_irq", irq, 1'b0);
      check_val("rst_ack", ack, 1'b0);
      check_val("rst_dat", dat_r, 32'h0);
      wb_read(32'h10, d); check_val("rst_tgt0", d, 6);
      wb_read(32'h14, d); check_val("rst_tgt1", d, 8);
      wb_read(32'h18, d); check_val("rst_tgt2", d, 10);
      wb_read(32'h00, d); check_val("rst_ctrl", d, 32'h700);
      wb_read(32'h04, d); check_val("rst_status", d, 32'h0);
      wb_read(32'h80, d); check_val("unmapped_rd", d, 32'h0);
      mon_en = 1'b1;

      // Full sequence across all three channels
      push_ramp(0, 0, 6, 0);
      push_ramp(1, 0, 8, SC + RD);
      push_ramp(2, 0, 10, SC + RD);
      irq0 = irq_total;
      wb_write(32'h00, 32'h701);
      check_val("full_busy", busy, 1'b1);
      wait_idle();
      check_val("full_irq", irq_total - irq0, 1);
      check_val("full_trim", trim, 48'h0400_0100_0040);
      wb_read(32'h04, d);
      check_val("full_done", (d >> 8) & 32'h7, 32'h7);
      check_val("full_state", (d >> 1) & 32'h3, 32'h0);
      check_val("full_act", (d >> 16) & 32'hF, 32'h2);
      wb_read(32'h44, d); check_val("full_cur1", d, 8);
      check_val("full_sb_empty", sb.size(), 0);

      // Clamp, then downward ramp on ch1 only
      wb_write(32'h14, 32'd20);
      wb_read(32'h14, d); check_val("clamp_tgt1", d, 15);
      wb_write(32'h14, 32'd2);
      push_ramp(1, 8, 2, 0);
      irq0 = irq_total;
      wb_write(32'h00, 32'h201);
      wait_idle();
      check_val("down_irq", irq_total - irq0, 1);
      check_val("down_trim", trim, trim_of());
      wb_read(32'h04, d);
      check_val("down_done", (d >> 8) & 32'h7, 32'h2);
      check_val("down_sb_empty", sb.size(), 0);

      // Abort on ch0 at index 3, then GO+ABORT together, then resume
      wb_write(32'h10, 32'd0);
      push_ramp(0, 6, 3, 0);
      irq0 = irq_total;
      wb_write(32'h00, 32'h101);
      wait_ch0(16'h0008);
      wb_write(32'h00, 32'h102);
      repeat (6) @(negedge clk);
      check_val("abort_busy", busy, 1'b0);
      check_val("abort_irq", irq_total - irq0, 0);
      wb_read(32'h04, d);
      check_val("abort_state", (d >> 1) & 32'h3, 32'h0);
      check_val("abort_done", (d >> 8) & 32'h7, 32'h0);
      wb_read(32'h40, d); check_val("abort_cur0", d, 3);
      check_val("abort_sb_empty", sb.size(), 0);
      wb_write(32'h00, 32'h103);
      repeat (4) @(negedge clk);
      check_val("goabort_busy", busy, 1'b0);
      check_val("goabort_irq", irq_total - irq0, 0);
      push_ramp(0, 3, 0, 0);
      wb_write(32'h00, 32'h101);
      wait_idle();
      check_val("resume_irq", irq_total - irq0, 1);
      wb_read(32'h40, d); check_val("resume_cur0", d, 0);
      check_val("resume_sb_empty", sb.size(), 0);

      // Empty enable mask
      wb_write(32'h00, 32'h000);
      irq0 = irq_total;
      wb_write(32'h00, 32'h001);
      repeat (3) @(negedge clk);
      check_val("empty_irq", irq_total - irq0, 1);
      check_val("empty_trim", trim, trim_of());
      check_val("empty_busy", busy, 1'b0);

      // Asynchronous reset in the middle of a ramp
      wb_write(32'h10, 32'd9);
      push_ramp(0, 0, 1, 0);
      wb_write(32'h00, 32'h701);
      wait_ch0(16'h0002);
      check_val("mid_busy", busy, 1'b1);
      m_cur[0] = 0; m_cur[1] = 0; m_cur[2] = 0;
      push_ramp(0, 1, 0, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_trim", trim, 48'h0001_0001_0001);
      check_val("arst_ack", ack, 1'b0);
      check_val("arst_irq", irq, 1'b0);
      check_val("arst_busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wb_read(32'h10, d); check_val("arst_tgt0", d, 6);
      check_val("arst_sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
